// File: rtl/shift_seq_pkg.sv
// Shared types for the shift sequencer: FSM states and register-core modes.
// Optional rotate support is enabled by defining SHIFT_SEQ_ROTATE_EN.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

endpackage

// File: rtl/shift_reg_core.sv
// Storage for the shift sequencer: parallel load, shift right/left, hold.
// Feature macro SHIFT_SEQ_ROTATE_EN is handled by the controller, not here.
module shift_reg_core
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] par_i,
  input  logic             sr_i,
  input  logic             sl_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;

  // sr_i enters at the MSB on a right shift, sl_i at the LSB on a left shift
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
    end else if (en_i) begin
      unique case (mode_i)
        MODE_LOAD: data_q <= par_i;
        MODE_SHR:  data_q <= {sr_i, data_q[WIDTH-1:1]};
        MODE_SHL:  data_q <= {data_q[WIDTH-2:0], sl_i};
        default:   data_q <= data_q;
      endcase
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a loadable shift register: accept, load, shift N, pulse done.
// Define SHIFT_SEQ_ROTATE_EN to add the cmd_rotate input (rotate instead of fill).
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             fill_bit,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             cmd_rotate,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int RW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [RW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ld_q, ld_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;
  logic             rot_q, rot_d;
  logic             en;
  logic [1:0]       mode;
  logic             sr_in, sl_in;
  logic [31:0]      cnt_ext;

  assign cnt_ext = 32'(cmd_count);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ld_q    <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      rot_q   <= rot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    rot_d   = rot_q;
    en      = 1'b0;
    mode    = MODE_HOLD;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ld_d   = cmd_data;
          dir_d  = cmd_dir;
          fill_d = fill_bit;
`ifdef SHIFT_SEQ_ROTATE_EN
          rot_d  = cmd_rotate;
`else
          rot_d  = 1'b0;
`endif
          // counts beyond the register width saturate at WIDTH
          if (cnt_ext > 32'(WIDTH)) cnt_d = RW'(WIDTH);
          else                      cnt_d = RW'(cmd_count);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        en   = 1'b1;
        mode = MODE_LOAD;
        state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        en    = 1'b1;
        mode  = dir_q ? MODE_SHL : MODE_SHR;
        cnt_d = cnt_q - RW'(1);
        if (cnt_q == RW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sr_in = rot_q ? data_out[0]       : fill_q;
  assign sl_in = rot_q ? data_out[WIDTH-1] : fill_q;

  shift_reg_core #(.WIDTH(WIDTH)) u_core (
    .clock  (clock),
    .reset  (reset),
    .en_i   (en),
    .mode_i (mode),
    .par_i  (ld_q),
    .sr_i   (sr_in),
    .sl_i   (sl_in),
    .data_o (data_out)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign ser_out   = dir_q ? data_out[WIDTH-1] : data_out[0];

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl.
// Rotate vector runs only when SHIFT_SEQ_ROTATE_EN is defined.
module tb_shift_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_dir;
  logic [3:0] cmd_count;
  logic       fill_bit;
  logic       cmd_rotate;
  logic [7:0] data_out;
  logic       ser_out;
  logic       busy;
  logic       done;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  shift_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
    .fill_bit  (fill_bit),
`ifdef SHIFT_SEQ_ROTATE_EN
    .cmd_rotate(cmd_rotate),
`endif
    .data_out  (data_out),
    .ser_out   (ser_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue a command, scramble inputs while busy, check done timing and result.
  task automatic run_cmd(input string tag, input logic [7:0] d,
                         input logic dir, input logic [3:0] cnt,
                         input logic fill, input logic rot,
                         input int n, input logic [7:0] exp);
    check({tag, ".ready"}, 32'(cmd_ready), 1);
    cmd_data   = d;
    cmd_dir    = dir;
    cmd_count  = cnt;
    fill_bit   = fill;
    cmd_rotate = rot;
    cmd_valid  = 1'b1;
    step();
    check({tag, ".busy"}, 32'(busy), 1);
    check({tag, ".nrdy"}, 32'(cmd_ready), 0);
    cmd_data  = ~d;
    cmd_dir   = ~dir;
    cmd_count = 4'hF;
    fill_bit  = ~fill;
    cmd_rotate = ~rot;
    for (int i = 1; i <= n + 1; i++) begin
      step();
      if (i < n + 1) check({tag, ".early"}, 32'(done), 0);
    end
    check({tag, ".done"}, 32'(done), 1);
    check({tag, ".data"}, 32'(data_out), 32'(exp));
    check({tag, ".ser"}, 32'(ser_out), 32'(dir ? exp[7] : exp[0]));
    cmd_valid = 1'b0;
    step();
    check({tag, ".pulse"}, 32'(done), 0);
    check({tag, ".idle"}, 32'(cmd_ready), 1);
    check({tag, ".hold"}, 32'(data_out), 32'(exp));
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_data   = '0;
    cmd_dir    = 1'b0;
    cmd_count  = '0;
    fill_bit   = 1'b0;
    cmd_rotate = 1'b0;
    step();
    step();
    check("rst.data", 32'(data_out), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.ready", 32'(cmd_ready), 1);
    check("rst.done", 32'(done), 0);
    check("rst.ser", 32'(ser_out), 0);
    reset = 1'b0;
    step();

    run_cmd("r1", 8'h5B, 1'b0, 4'd1, 1'b1, 1'b0, 1, 8'hAD);
    run_cmd("l2", 8'h5B, 1'b1, 4'd2, 1'b0, 1'b0, 2, 8'h6C);
    run_cmd("c0", 8'h5B, 1'b0, 4'd0, 1'b1, 1'b0, 0, 8'h5B);
    run_cmd("clamp", 8'hFF, 1'b0, 4'd12, 1'b0, 1'b0, 8, 8'h00);
    run_cmd("l3f1", 8'h00, 1'b1, 4'd3, 1'b1, 1'b0, 3, 8'h07);
`ifdef SHIFT_SEQ_ROTATE_EN
    run_cmd("rot", 8'h81, 1'b0, 4'd1, 1'b0, 1'b1, 1, 8'hC0);
`endif

    // reset in the middle of a shift sequence
    cmd_data  = 8'hA5;
    cmd_dir   = 1'b0;
    cmd_count = 4'd5;
    fill_bit  = 1'b1;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("abort.busy0", 32'(busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort.data", 32'(data_out), 0);
    check("abort.busy", 32'(busy), 0);
    check("abort.ready", 32'(cmd_ready), 1);
    check("abort.done", 32'(done), 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("abort.nodone", 32'(done), 0);
    end

    // reset wins over a simultaneous handshake
    cmd_valid = 1'b1;
    reset     = 1'b1;
    step();
    reset     = 1'b0;
    cmd_valid = 1'b0;
    check("prio.busy", 32'(busy), 0);
    check("prio.ready", 32'(cmd_ready), 1);
    step();
    check("prio.stay", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of the sequenced shift register.
REQ-002 SHALL have parameter CNT_W, default 4, width of the shift-count field.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  controller can accept a command.
REQ-007 SHALL have port cmd_data  input  WIDTH  parallel load value.
REQ-008 SHALL have port cmd_dir  input  1  0 = shift right (toward bit 0), 1 = shift left.
REQ-009 SHALL have port cmd_count  input  CNT_W  number of shifts requested.
REQ-010 SHALL have port fill_bit  input  1  bit entering the vacated end on each shift.
REQ-011 SHALL have port data_out  output  WIDTH  current shift-register contents.
REQ-012 SHALL have port ser_out  output  1  data_out[0] when the latched direction is right, else data_out[WIDTH-1]; combinational.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, SHIFT and DONE.
REQ-016 SHALL hold cmd_ready high only in IDLE; acceptance is the rising edge E0 at which cmd_valid and cmd_ready are both high.
REQ-017 SHALL, at E0, latch cmd_data, cmd_dir, fill_bit and the clamped count (counts above WIDTH become WIDTH), then enter LOAD.
REQ-018 SHALL, in LOAD, parallel-load the latched data at the next edge; go to SHIFT if count > 0, else to DONE.
REQ-019 SHALL, in SHIFT, perform exactly one shift per edge in the latched direction, inserting the latched fill bit, and decrement the remaining count; go to DONE after the last shift.
REQ-020 SHALL assert done for exactly one cycle, in DONE, visible after edge E0+N+1 (N = clamped count), with data_out final; DONE goes to IDLE at the next edge.
REQ-021 SHALL hold register contents (mode HOLD) in IDLE and DONE; data_out is stable between commands.
REQ-022 SHALL ignore cmd_valid and input changes while busy; only latched values govern an operation in progress.
REQ-023 SHALL accept back-to-back commands no sooner than the cycle after DONE; minimum command period is N+3 cycles.

Reset
REQ-024 SHALL, on a reset edge, force state IDLE, data_out 0, remaining count 0, latched direction right, done 0, busy 0 and cmd_ready 1.
REQ-025 SHALL abort any operation in progress on reset without asserting done; reset has priority over a simultaneous command handshake.

Configuration
REQ-026 SHALL, with SHIFT_SEQ_ROTATE_EN defined, add input cmd_rotate (1 bit, latched at E0); when it is set, the bit shifted out re-enters the opposite end and fill_bit is ignored.
REQ-027 SHALL, without SHIFT_SEQ_ROTATE_EN, omit cmd_rotate and always insert the latched fill bit.

Structure
REQ-028 SHALL take the FSM state enum and the 2-bit mode constants (LOAD=00, SHR=01, SHL=10, HOLD=11) from package shift_seq_pkg.
REQ-029 SHALL place the storage in sub-module shift_reg_core, which has clock, an enable, a 2-bit mode, a parallel input, a right-serial input and a left-serial input; shift_seq_ctrl contains only the sequencing logic.

Verification
REQ-030 SHALL cover: load 0x5B, dir right, count 1, fill 1 -> data_out 0xAD, done after E0+2.
REQ-031 SHALL cover: load 0x5B, dir left, count 2, fill 0 -> data_out 0x6C, done after E0+3, cmd_ready 1 after E0+4.
REQ-032 SHALL cover: load 0x5B, count 0 -> data_out 0x5B, done after E0+1.
REQ-033 SHALL cover: load 0xFF, dir right, count 12, fill 0 -> clamped to 8, data_out 0x00, done after E0+9.
REQ-034 SHALL cover: reset asserted during SHIFT -> after that edge data_out 0x00, busy 0, cmd_ready 1, no done pulse.
REQ-035 SHALL cover, with SHIFT_SEQ_ROTATE_EN defined: load 0x81, dir right, count 1, cmd_rotate 1 -> data_out 0xC0.
